// File: rtl/simply5_pkg.sv
// rtl/simply5_pkg.sv - shared RV32 opcode/funct constants and arbiter state type
package simply5_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle combinational RV32 integer ALU (R-type and I-type ops)
module alu
  import simply5_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        func3_i,
  input  logic [6:0]        func7_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] sra_res;

  assign shamt   = data2_i[SH_W-1:0];
  // kept apart so the arithmetic shift is not demoted to unsigned by a ternary
  assign sra_res = $unsigned($signed(data1_i) >>> shamt);

  always_comb begin
    result_o = '0;
    if (opcode_i == OP_RTYPE || opcode_i == OP_ITYPE) begin
      case (func3_i)
        3'b000:  result_o = (opcode_i == OP_RTYPE && func7_i == F7_SUB) ?
                            data1_i - data2_i : data1_i + data2_i;
        3'b001:  result_o = data1_i << shamt;
        3'b010:  result_o = DATA_W'($signed(data1_i) < $signed(data2_i));
        3'b011:  result_o = DATA_W'(data1_i < data2_i);
        3'b100:  result_o = data1_i ^ data2_i;
        3'b101:  result_o = (func7_i == F7_ADD) ? data1_i >> shamt : sra_res;
        3'b110:  result_o = data1_i | data2_i;
        default: result_o = data1_i & data2_i;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one alu between NUM_REQ valid/ready requesters
module alu_arbiter
  import simply5_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data1_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data2_i,
  input  logic [NUM_REQ-1:0][6:0]          req_opcode_i,
  input  logic [NUM_REQ-1:0][2:0]          req_func3_i,
  input  logic [NUM_REQ-1:0][6:0]          req_func7_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [DATA_W-1:0]                rsp_result_o,
  output logic                             busy_o,
  output logic [$clog2(NUM_REQ)-1:0]       owner_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, owner_q, grant, scan;
  logic              grant_valid, req_fire, rsp_fire;
  logic [DATA_W-1:0] data1_q, data2_q, result_q, alu_result;
  logic [6:0]        opcode_q, func7_q;
  logic [2:0]        func3_q;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // first valid requester at or after rr_ptr, wrapping past NUM_REQ-1
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    scan        = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid_i[scan]) begin
        grant_valid = 1'b1;
        grant       = scan;
      end
      scan = next_idx(scan);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req_fire = 1'b0;
    rsp_fire = 1'b0;
    case (state_q)
      IDLE: if (grant_valid) begin
        req_fire = 1'b1;
        state_d  = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready_i[owner_q]) begin
        rsp_fire = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      opcode_q <= '0;
      func3_q  <= '0;
      func7_q  <= '0;
      result_q <= '0;
    end else begin
      if (req_fire) begin
        owner_q  <= grant;
        data1_q  <= req_data1_i[grant];
        data2_q  <= req_data2_i[grant];
        opcode_q <= req_opcode_i[grant];
        func3_q  <= req_func3_i[grant];
        func7_q  <= req_func7_i[grant];
      end
      if (state_q == EXEC) result_q <= alu_result;
      if (rsp_fire)        rr_ptr_q <= next_idx(owner_q);
    end
  end

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .data1_i (data1_q),
    .data2_i (data2_q),
    .opcode_i(opcode_q),
    .func3_i (func3_q),
    .func7_i (func7_q),
    .result_o(alu_result)
  );

  assign req_ready_o  = (state_q == IDLE && grant_valid) ?
                        ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;
  assign rsp_valid_o  = (state_q == RESP) ?
                        ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign rsp_result_o = result_q;
  assign busy_o       = (state_q != IDLE);
  assign owner_o      = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a transaction model
module tb_alu_arbiter;

  localparam int N = 2;
  localparam int W = 32;
  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] F_SUB = 7'b0100000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][W-1:0] d1, d2;
  logic [N-1:0][6:0]   op, f7;
  logic [N-1:0][2:0]   f3;
  logic [W-1:0]        rsp_result;
  logic                busy;
  logic [0:0]          owner;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data1_i (d1),
    .req_data2_i (d2),
    .req_opcode_i(op),
    .req_func3_i (f3),
    .req_func7_i (f7),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RV32 semantics for the two supported opcode classes; anything else yields zero
  function automatic logic [W-1:0] ref_alu(input logic [6:0] o, input logic [2:0] fn3,
                                           input logic [6:0] fn7, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sa, sb, sh;
    logic [W-1:0] r;
    sa = int'(a);
    sb = int'(b);
    sh = int'(b[4:0]);
    if (o != R_OP && o != I_OP) return '0;
    case (fn3)
      3'd0: r = (o == R_OP && fn7 == F_SUB) ? W'(sa - sb) : W'(sa + sb);
      3'd1: r = a << sh;
      3'd2: r = (sa < sb) ? 1 : 0;
      3'd3: r = (a < b) ? 1 : 0;
      3'd4: r = a ^ b;
      3'd5: r = (fn7 == 7'd0) ? (a >> sh) : W'(sa >>> sh);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7);
    d1[r] = a; d2[r] = b; op[r] = o; f3[r] = fn3; f7[r] = fn7;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0;
    d1 = '0; d2 = '0; op = '0; f3 = '0; f7 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int m_phase, m_rr, m_owner, g;
  logic [W-1:0] m_res;
  bit found;

  initial begin
    // reset state
    do_reset();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_req_ready", req_ready, 0);

    // single add on req0, operand isolation, back-pressure
    @(posedge clk); #1;
    set_req(0, 6, 5, R_OP, 3'd0, 7'd0);
    set_req(1, 6, 5, R_OP, 3'd0, F_SUB);
    req_valid = 2'b01;
    @(negedge clk);
    check("add_ready_c0", req_ready, 2'b01);
    check("add_busy_c0", busy, 0);
    @(posedge clk); #1;
    req_valid = 2'b10;
    d1[0] = 100;
    @(negedge clk);
    check("add_busy_c1", busy, 1);
    check("add_ready_c1", req_ready, 0);
    check("add_rspv_c1", rsp_valid, 0);
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    @(negedge clk);
    check("add_rspv_c2", rsp_valid, 2'b01);
    check("add_result_c2", rsp_result, 11);
    check("add_busy_c2", busy, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_rspv", rsp_valid, 2'b01);
      check("bp_result", rsp_result, 11);
      check("bp_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_release_rspv", rsp_valid, 2'b01);
    check("bp_release_ready", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    check("sub_ready", req_ready, 2'b10);
    check("sub_rspv_idle", rsp_valid, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("sub_owner", owner, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("sub_rspv", rsp_valid, 2'b10);
    check("sub_result", rsp_result, 1);
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;

    // fairness: both requesters always valid, always ready for results
    do_reset();
    @(posedge clk); #1;
    set_req(0, 20, 3, R_OP, 3'd0, 7'd0);
    set_req(1, 20, 3, R_OP, 3'd0, F_SUB);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("fair_ready", req_ready, (c % 3 == 0) ? (64'd1 << ((c / 3) % 2)) : 64'd0);
      check("fair_rspv", rsp_valid, (c % 3 == 2) ? (64'd1 << ((c / 3) % 2)) : 64'd0);
      if (c % 3 == 2) check("fair_result", rsp_result, ((c / 3) % 2 == 0) ? 23 : 17);
      @(posedge clk); #1;
    end

    // reset during EXEC discards the op and restarts the round-robin pointer
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1, 2, R_OP, 3'd0, 7'd0);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("rmo_ready0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rmo_ready1", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check("rmo_busy", busy, 0);
    check("rmo_rspv", rsp_valid, 0);
    check("rmo_owner", owner, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmo_rspv_hold", rsp_valid, 0);
    end
    set_req(0, 7, 8, R_OP, 3'd0, 7'd0);
    set_req(1, 9, 4, R_OP, 3'd0, F_SUB);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    rst_n = 1'b1;
    #1;
    check("rmo_rr_restart", req_ready, 2'b01);
    req_valid = 2'b10;
    #1;
    check("rmo_req1_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check("rmo_req1_rspv", rsp_valid, 2'b10);
    check("rmo_req1_result", rsp_result, 5);

    // randomized traffic against a transaction-level model
    do_reset();
    m_phase = 0; m_rr = 0; m_owner = 0; m_res = '0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      req_valid = N'($urandom_range(0, 3));
      rsp_ready = N'($urandom_range(0, 3));
      for (int r = 0; r < N; r++) begin
        int k;
        k = $urandom_range(0, 3);
        d1[r] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom());
        d2[r] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom());
        op[r] = (k < 2) ? R_OP : (k == 2) ? I_OP : 7'($urandom());
        f3[r] = 3'($urandom());
        k = $urandom_range(0, 2);
        f7[r] = (k == 0) ? 7'd0 : (k == 1) ? F_SUB : 7'($urandom());
      end
      @(negedge clk);
      if (m_phase == 0) begin
        found = 1'b0;
        g = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_rr + k) % N]) begin
            found = 1'b1;
            g = (m_rr + k) % N;
          end
        end
        check("rnd_idle_ready", req_ready, found ? (64'd1 << g) : 64'd0);
        check("rnd_idle_rspv", rsp_valid, 0);
        check("rnd_idle_busy", busy, 0);
        if (found) begin
          m_owner = g;
          m_res   = ref_alu(op[g], f3[g], f7[g], d1[g], d2[g]);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        check("rnd_exec_ready", req_ready, 0);
        check("rnd_exec_rspv", rsp_valid, 0);
        check("rnd_exec_busy", busy, 1);
        check("rnd_exec_owner", owner, m_owner);
        m_phase = 2;
      end else begin
        check("rnd_resp_rspv", rsp_valid, 64'd1 << m_owner);
        check("rnd_resp_result", rsp_result, m_res);
        check("rnd_resp_ready", req_ready, 0);
        check("rnd_resp_owner", owner, m_owner);
        if (rsp_ready[m_owner]) begin
          m_phase = 0;
          m_rr    = (m_owner + 1) % N;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle combinational `alu` between `NUM_REQ` requesters, such as the execute stage and the branch/address-calculation path, using per-requester valid/ready handshakes. It latches the winning requester's operands and control fields, evaluates them on the internal `alu`, and returns a registered result to that requester. The result is held until the requester accepts it. Grants rotate round-robin so no requester starves.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; must be ≥2.
- `DATA_W`, default 32: operand and result width; must match `alu`.

Ports:
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_ni`, in, 1: reset. Asynchronous assert, active-low.
- `req_valid_i`, in, `NUM_REQ`: request valid, one bit per requester.
- `req_ready_o`, out, `NUM_REQ`: request accepted, one-hot or zero.
- `req_data1_i`, in, `NUM_REQ`×`DATA_W`: operand 1 per requester.
- `req_data2_i`, in, `NUM_REQ`×`DATA_W`: operand 2 per requester.
- `req_opcode_i`, in, `NUM_REQ`×7: RV32 opcode per requester.
- `req_func3_i`, in, `NUM_REQ`×3: funct3 per requester.
- `req_func7_i`, in, `NUM_REQ`×7: funct7 per requester.
- `rsp_valid_o`, out, `NUM_REQ`: result valid, one-hot or zero.
- `rsp_ready_i`, in, `NUM_REQ`: requester accepts the result.
- `rsp_result_o`, out, `DATA_W`: shared result bus; meaningful only where `rsp_valid_o` is set.
- `busy_o`, out, 1: high whenever state ≠ IDLE.
- `owner_o`, out, `$clog2(NUM_REQ)`: index of the requester currently being served.

## Operation
- State machine with three states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant = first requester with `req_valid_i` set, searching from `rr_ptr` upward and wrapping to 0.
  - `req_ready_o[grant]`=1; all other ready bits 0. Ready may depend combinationally on valid.
  - On handshake (`req_valid_i[g] & req_ready_o[g]`): latch data1, data2, opcode, func3 and func7 into operand registers, set owner=g, go to EXEC.
  - No valid requests: remain in IDLE.
- **EXEC**
  - Internal `alu` is driven only from the latched registers; requester inputs are ignored.
  - At the clock edge, capture `alu.result_o` into the result register and go to RESP.
- **RESP**
  - `rsp_valid_o[owner]`=1 and `rsp_result_o` = result register, both held stable.
  - On `rsp_ready_i[owner]`: go to IDLE and set `rr_ptr` = owner+1 (wraps to 0 at `NUM_REQ`).
  - `rsp_ready_i` bits of non-owners are ignored.
- `req_ready_o` is 0 in EXEC and RESP. There is no overlap between operations.
- Opcode and funct decoding belong entirely to `alu`; the arbiter passes all fields through unchanged, including unsupported opcodes.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, owner=0.
  - `rsp_valid_o`=0, `rsp_result_o`=0.
  - `busy_o`=0, `owner_o`=0.
  - Operand registers = 0.
- Latency: request handshake at cycle N → EXEC in N+1 → `rsp_valid_o` high from N+2.
- Best-case throughput: one operation per 3 cycles, when `rsp_ready_i` is high in the first RESP cycle.
- Back-pressure: RESP is held indefinitely; result and valid stay stable, and no new grant is issued.
- A request withdrawn in IDLE before handshake is not an error; the grant re-evaluates every cycle.
- Operand changes after the handshake have no effect on the result.
- Reset asserted in any state: return immediately to reset values. Any in-flight operation is discarded and never responded to.
- Only one response can ever be pending, so there are no simultaneous-response conflicts.

## Structure
- Shared package `simply5_pkg` holds:
  - opcode constants (`OP_RTYPE`=7'b0110011, `OP_ITYPE`=7'b0010011),
  - funct7 constants (`F7_ADD`=7'b0000000, `F7_SUB`=7'b0100000),
  - the `arb_state_e` enum {IDLE, EXEC, RESP}.
- One sub-module: the existing `alu`, instantiated once with ports `data1_i`, `data2_i`, `opcode_i`, `func3_i`, `func7_i`, `result_o`.
- Round-robin grant logic stays local: a function or always_comb block, not a separate module.

## Test plan
- **Single add:** req0 sends data1=6, data2=5, opcode=0110011, func3=0, func7=0 at cycle 0 → `req_ready_o`=01 in cycle 0; `rsp_valid_o`=01 and `rsp_result_o`=11 in cycle 2; `busy_o`=1 for cycles 1–2.
- **Subtract on req1:** same operands with func7=0100000 from req1 → `rsp_valid_o`=10 and `rsp_result_o`=1 two cycles after handshake.
- **Fairness:** both requesters continuously valid from reset with `rsp_ready_i`=11 → grant order 0,1,0,1; each requester gets a result every 6 cycles.
- **Back-pressure:** `rsp_ready_i`=00 for 5 cycles in RESP → `rsp_valid_o` and `rsp_result_o` stable, `req_ready_o`=00 throughout; the next grant occurs the cycle after `rsp_ready_i[owner]` rises.
- **Operand isolation:** after handshake with 6/5 add, change `req_data1_i[0]` to 100 → result is still 11.
- **Reset mid-op:** drop `rst_ni` during EXEC → `rsp_valid_o` never rises and `busy_o`=0 immediately; after release, the first request from req1 alone is granted and returns the correct result (`rr_ptr` restarted at 0).
